gdc_door_actuator: RTL and testbench

Behavioural model of the garage-door plant: motor plus door plus limit switches. It sits at the far end of the door controller's motor-drive interface. It consumes the up_m/dn_m motor commands and tracks door position with a prescaled travel counter. It returns up_max/dn_max limit-switch levels to the controller, so the controller can be exercised closed-loop in simulation and on an FPGA demo board.

---
 rtl/gdc_pkg.sv | 23 ++
 rtl/gdc_door_actuator_if.sv | 23 ++
 rtl/gdc_step_timer.sv | 41 ++++
 rtl/gdc_door_actuator.sv | 125 ++++++++++++
 tb/tb_gdc_door_actuator.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gdc_pkg.sv
// Shared garage-door definitions: actuator state encoding and travel direction.
// The door controller reuses the direction constants.
package gdc_pkg;

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_START_UP  = 3'd1,
    ST_MOVING_UP = 3'd2,
    ST_START_DN  = 3'd3,
    ST_MOVING_DN = 3'd4,
    ST_FAULT     = 3'd5
  } act_state_t;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } door_dir_t;

  function automatic logic is_moving(act_state_t s);
    return (s == ST_MOVING_UP) || (s == ST_MOVING_DN);
  endfunction

endpackage

// File: rtl/gdc_door_actuator_if.sv
// Motor-drive / limit-switch link between the door controller (master)
// and the door plant model (slave).
interface gdc_door_actuator_if #(parameter int POS_W = 8);
  logic             up_m;
  logic             dn_m;
  logic             obstruct;
  logic             up_max;
  logic             dn_max;
  logic [POS_W-1:0] pos;
  logic             moving;
  logic             stall;
  logic             fault;

  modport master (
    output up_m, dn_m, obstruct,
    input  up_max, dn_max, pos, moving, stall, fault
  );

  modport slave (
    input  up_m, dn_m, obstruct,
    output up_max, dn_max, pos, moving, stall, fault
  );
endinterface

// File: rtl/gdc_step_timer.sv
// Motor spin-up delay counter and travel-step prescaler for the door plant.
// clr has priority over counting; hold freezes only the prescaler.
module gdc_step_timer #(
  parameter int STEP_DIV  = 16,
  parameter int START_DLY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic dly_en,
  input  logic step_en,
  input  logic hold,
  output logic start_done,
  output logic step
);
  localparam int DLY_W = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DLY - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [DLY_W-1:0] dly_q;
  logic [PRE_W-1:0] pre_q;

  assign start_done = dly_en && (dly_q == DLY_LAST);
  assign step       = step_en && !hold && (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q <= '0;
      pre_q <= '0;
    end else if (clr) begin
      dly_q <= '0;
      pre_q <= '0;
    end else begin
      if (dly_en && !start_done)
        dly_q <= dly_q + 1'b1;
      if (step_en && !hold)
        pre_q <= step ? '0 : pre_q + 1'b1;
    end
  end
endmodule

// File: rtl/gdc_door_actuator.sv
// Garage-door plant model: turns up_m/dn_m motor drive into door position
// and limit-switch levels so the controller can run closed-loop.
//
// state        | meaning
// ST_STOPPED   | motor off, door at rest
// ST_START_UP  | motor spinning up in the open direction
// ST_MOVING_UP | door travelling towards open
// ST_START_DN  | motor spinning up in the close direction
// ST_MOVING_DN | door travelling towards closed (frozen while obstructed)
// ST_FAULT     | both drives asserted, position frozen
module gdc_door_actuator
  import gdc_pkg::*;
#(
  parameter int TRAVEL_STEPS = 200,
  parameter int STEP_DIV     = 16,
  parameter int START_DLY    = 8,
  parameter int INIT_POS     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  gdc_door_actuator_if.slave   bus
);
  localparam int POS_W = $clog2(TRAVEL_STEPS + 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(TRAVEL_STEPS);
  localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);

  act_state_t       state_q, state_d;
  door_dir_t        run_dir;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             at_lim_d;
  logic             up_max_q, dn_max_q, moving_q, stall_q, fault_q;
  logic             clr, dly_en, step_en, hold, start_done, step;

  // Any state change restarts both counters, so every START_* and MOVING_*
  // visit begins from zero and a partial step is discarded on exit.
  assign clr     = (state_d != state_q) || (state_q == ST_STOPPED) || (state_q == ST_FAULT);
  assign dly_en  = (state_q == ST_START_UP) || (state_q == ST_START_DN);
  assign step_en = is_moving(state_q);
  assign hold    = (state_q == ST_MOVING_DN) && bus.obstruct;

  gdc_step_timer #(
    .STEP_DIV  (STEP_DIV),
    .START_DLY (START_DLY)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .dly_en     (dly_en),
    .step_en    (step_en),
    .hold       (hold),
    .start_done (start_done),
    .step       (step)
  );

  always_comb begin
    run_dir = (state_q == ST_MOVING_UP) ? DIR_UP : DIR_DN;
    state_d = state_q;
    if (bus.up_m && bus.dn_m) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (bus.up_m)      state_d = ST_START_UP;
          else if (bus.dn_m) state_d = ST_START_DN;
        end
        ST_START_UP: begin
          if (!bus.up_m)       state_d = ST_STOPPED;
          else if (start_done) state_d = ST_MOVING_UP;
        end
        ST_START_DN: begin
          if (!bus.dn_m)       state_d = ST_STOPPED;
          else if (start_done) state_d = ST_MOVING_DN;
        end
        ST_MOVING_UP: begin
          if (!bus.up_m) state_d = ST_STOPPED;
        end
        ST_MOVING_DN: begin
          if (!bus.obstruct && !bus.dn_m) state_d = ST_STOPPED;
        end
        ST_FAULT: begin
          if (!bus.up_m && !bus.dn_m) state_d = ST_STOPPED;
        end
        default: state_d = ST_STOPPED;
      endcase
    end

    pos_d = pos_q;
    if (is_moving(state_q) && (state_d == state_q) && step) begin
      if (run_dir == DIR_UP && pos_q < POS_MAX)
        pos_d = pos_q + 1'b1;
      else if (run_dir == DIR_DN && pos_q != '0)
        pos_d = pos_q - 1'b1;
    end

    at_lim_d = (state_d == ST_MOVING_UP) ? (pos_d == POS_MAX) : (pos_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_STOPPED;
      pos_q    <= POS_INIT;
      up_max_q <= (INIT_POS == TRAVEL_STEPS);
      dn_max_q <= (INIT_POS == 0);
      moving_q <= 1'b0;
      stall_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      up_max_q <= (pos_d == POS_MAX);
      dn_max_q <= (pos_d == '0);
      moving_q <= ((state_d == ST_MOVING_UP) && !at_lim_d) ||
                  ((state_d == ST_MOVING_DN) && !at_lim_d && !bus.obstruct);
      stall_q  <= is_moving(state_d) && at_lim_d;
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign bus.pos    = pos_q;
  assign bus.up_max = up_max_q;
  assign bus.dn_max = dn_max_q;
  assign bus.moving = moving_q;
  assign bus.stall  = stall_q;
  assign bus.fault  = fault_q;
endmodule

// File: tb/tb_gdc_door_actuator.sv
// Bench for the door plant: two instances (closed / open at reset) driven with
// directed and random motor commands, checked against a phase-based door model.
module tb_gdc_door_actuator;
  localparam int TS   = 10;
  localparam int SD   = 4;
  localparam int SDLY = 2;
  localparam int PW   = $clog2(TS + 1);

  localparam int PH_IDLE  = 0;
  localparam int PH_SPIN  = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_FAULT = 3;

  typedef struct {
    int pos;
    bit up_max;
    bit dn_max;
    bit moving;
    bit stall;
    bit fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gdc_door_actuator_if #(.POS_W(PW)) bus0 ();
  gdc_door_actuator_if #(.POS_W(PW)) bus1 ();

  gdc_door_actuator #(.TRAVEL_STEPS(TS), .STEP_DIV(SD), .START_DLY(SDLY), .INIT_POS(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gdc_door_actuator #(.TRAVEL_STEPS(TS), .STEP_DIV(SD), .START_DLY(SDLY), .INIT_POS(TS))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Door model: phase + direction + remaining spin-up edges + edges into the current step.
  int m_pos[2], m_phase[2], m_dir[2], m_spin[2], m_prog[2];
  bit m_obs[2];

  function automatic void model_reset(int k);
    m_pos[k]   = (k == 0) ? 0 : TS;
    m_phase[k] = PH_IDLE;
    m_dir[k]   = 0;
    m_spin[k]  = 0;
    m_prog[k]  = 0;
    m_obs[k]   = 1'b0;
  endfunction

  function automatic exp_t model_view(int k);
    exp_t e;
    bit   running, at_lim;
    running  = (m_phase[k] == PH_RUN);
    at_lim   = (m_dir[k] > 0) ? (m_pos[k] == TS) : (m_pos[k] == 0);
    e.pos    = m_pos[k];
    e.up_max = (m_pos[k] == TS);
    e.dn_max = (m_pos[k] == 0);
    e.moving = running && !at_lim && !(m_dir[k] < 0 && m_obs[k]);
    e.stall  = running && at_lim;
    e.fault  = (m_phase[k] == PH_FAULT);
    return e;
  endfunction

  function automatic exp_t model_step(int k, bit u, bit d, bit o);
    bit cmd;
    m_obs[k] = o;
    cmd = (m_dir[k] > 0) ? u : d;
    if (u && d) begin
      m_phase[k] = PH_FAULT;
    end else begin
      case (m_phase[k])
        PH_IDLE: begin
          if (u || d) begin
            m_phase[k] = PH_SPIN;
            m_dir[k]   = u ? 1 : -1;
            m_spin[k]  = SDLY;
          end
        end
        PH_SPIN: begin
          if (!cmd) m_phase[k] = PH_IDLE;
          else begin
            m_spin[k] = m_spin[k] - 1;
            if (m_spin[k] == 0) begin
              m_phase[k] = PH_RUN;
              m_prog[k]  = 0;
            end
          end
        end
        PH_RUN: begin
          if (m_dir[k] < 0 && o) begin
            // closing travel frozen by the beam
          end else if (!cmd) begin
            m_phase[k] = PH_IDLE;
          end else begin
            m_prog[k] = m_prog[k] + 1;
            if (m_prog[k] == SD) begin
              m_prog[k] = 0;
              m_pos[k]  = m_pos[k] + m_dir[k];
              if (m_pos[k] > TS) m_pos[k] = TS;
              if (m_pos[k] < 0)  m_pos[k] = 0;
            end
          end
        end
        default: begin
          if (!u && !d) m_phase[k] = PH_IDLE;
        end
      endcase
    end
    return model_view(k);
  endfunction

  function automatic exp_t dut_view(int k);
    exp_t e;
    if (k == 0) begin
      e.pos = int'(bus0.pos); e.up_max = bus0.up_max; e.dn_max = bus0.dn_max;
      e.moving = bus0.moving; e.stall = bus0.stall; e.fault = bus0.fault;
    end else begin
      e.pos = int'(bus1.pos); e.up_max = bus1.up_max; e.dn_max = bus1.dn_max;
      e.moving = bus1.moving; e.stall = bus1.stall; e.fault = bus1.fault;
    end
    return e;
  endfunction

  task automatic compare(string name, exp_t got, exp_t exp);
    n_vec++;
    if (got.pos != exp.pos || got.up_max != exp.up_max || got.dn_max != exp.dn_max ||
        got.moving != exp.moving || got.stall != exp.stall || got.fault != exp.fault) begin
      n_err++;
      $display("FAIL %s @%0t: got pos=%0d up_max=%0b dn_max=%0b moving=%0b stall=%0b fault=%0b, expected pos=%0d up_max=%0b dn_max=%0b moving=%0b stall=%0b fault=%0b",
               name, $time, got.pos, got.up_max, got.dn_max, got.moving, got.stall, got.fault,
               exp.pos, exp.up_max, exp.dn_max, exp.moving, exp.stall, exp.fault);
    end
  endtask

  task automatic expect_int(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic drive(bit u, bit d, bit o);
    @(negedge clk);
    bus0.up_m = u; bus0.dn_m = d; bus0.obstruct = o;
    bus1.up_m = u; bus1.dn_m = d; bus1.obstruct = o;
    q0.push_back(model_step(0, u, d, o));
    q1.push_back(model_step(1, u, d, o));
  endtask

  task automatic idle_inputs();
    bus0.up_m = 1'b0; bus0.dn_m = 1'b0; bus0.obstruct = 1'b0;
    bus1.up_m = 1'b0; bus1.dn_m = 1'b0; bus1.obstruct = 1'b0;
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare({name, "_dut0"}, dut_view(0), model_view(0));
    compare({name, "_dut1"}, dut_view(1), model_view(1));
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: one expected vector per DUT per clock edge that had stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) compare("edge_dut0", dut_view(0), q0.pop_front());
      if (q1.size() > 0) compare("edge_dut1", dut_view(1), q1.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit hit;
    bit req_up;
    idle_inputs();
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    compare("reset_init0", dut_view(0), '{pos: 0,  up_max: 0, dn_max: 1, moving: 0, stall: 0, fault: 0});
    compare("reset_init10", dut_view(1), '{pos: TS, up_max: 1, dn_max: 0, moving: 0, stall: 0, fault: 0});
    rst = 1'b1;

    // Full open: up_max latency from the capturing edge.
    hit = 0; lat = 0;
    for (int n = 1; n <= 80 && !hit; n++) begin
      drive(1, 0, 0);
      @(posedge clk); #2;
      if (bus0.up_max) begin hit = 1; lat = n - 1; end
    end
    expect_int("open_latency", hit ? lat : -1, SDLY + TS * SD);
    repeat (5) drive(1, 0, 0);
    @(posedge clk); #2;
    expect_int("open_stall", int'(bus0.stall), 1);
    expect_int("open_moving", int'(bus0.moving), 0);
    expect_int("open_pos", int'(bus0.pos), TS);

    // Full close with a 10-cycle obstruction mid-travel.
    repeat (2) drive(0, 0, 0);
    hit = 0; lat = 0;
    for (int n = 1; n <= 100 && !hit; n++) begin
      drive(0, 1, (n >= 20 && n < 30));
      @(posedge clk); #2;
      if (n == 25) begin
        expect_int("obstruct_moving", int'(bus0.moving), 0);
        expect_int("obstruct_pos", int'(bus0.pos), m_pos[0]);
      end
      if (bus0.dn_max) begin hit = 1; lat = n - 1; end
    end
    expect_int("close_latency", hit ? lat : -1, SDLY + TS * SD + 10);

    // Open to 5, then reverse in one cycle.
    repeat (2) drive(0, 0, 0);
    repeat (1 + SDLY + 5 * SD) drive(1, 0, 0);
    @(posedge clk); #2;
    expect_int("reverse_pos5", int'(bus0.pos), 5);
    hit = 0; lat = 0;
    for (int n = 1; n <= 40; n++) begin
      drive(0, 1, 0);
      @(posedge clk); #2;
      if (!hit && bus0.pos == 4) begin hit = 1; lat = n; end
    end
    expect_int("reverse_first_step", hit ? lat : -1, 2 + SDLY + SD);
    expect_int("reverse_no_wrap", int'(bus0.pos), 0);

    // Fault during MOVING_UP, then release.
    repeat (2) drive(0, 0, 0);
    repeat (8) drive(1, 0, 0);
    drive(1, 1, 0);
    @(posedge clk); #2;
    expect_int("fault_set", int'(bus0.fault), 1);
    expect_int("fault_pos", int'(bus0.pos), 1);
    repeat (3) drive(1, 1, 0);
    drive(0, 0, 0);
    @(posedge clk); #2;
    expect_int("fault_clear", int'(bus0.fault), 0);

    // Reset mid-move.
    repeat (12) drive(1, 0, 0);
    do_reset("reset_midmove");

    // Closed loop: a minimal controller opens on an activate pulse at dn_max.
    req_up = bus0.dn_max;
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      drive(req_up, 0, 0);
      @(posedge clk); #2;
      if (bus0.up_max) begin hit = 1; req_up = 0; end
    end
    expect_int("loop_reached_open", int'(hit), 1);
    repeat (20) drive(0, 0, 0);
    @(posedge clk); #2;
    expect_int("loop_stays_open", int'(bus0.pos), TS);

    // Random command segments.
    for (int s = 0; s < 70; s++) begin
      int kind, len;
      bit u, d;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      u = (kind <= 3) || (kind == 9);
      d = (kind >= 4 && kind <= 7) || (kind == 9);
      for (int c = 0; c < len; c++)
        drive(u, d, ($urandom_range(0, 7) == 0));
    end
    repeat (2) drive(0, 0, 0);
    @(posedge clk); #3;
    expect_int("queue_drain", q0.size() + q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
